// File: rtl/othello_pipeline.sv
// Othello endgame solver: iterative alpha-beta negamax over an on-chip frame stack,
// one search step per clock, exact disc differential reported for the side to move.
module othello_pipeline #(
  parameter int unsigned MAX_DEPTH = 24,
  parameter int unsigned SCORE_W   = 8
) (
  input  logic                      iCLOCK,
  input  logic                      iRESET,
  input  logic                      enable,
  input  logic [63:0]               iPlayer,
  input  logic [63:0]               iOpponent,
  output logic                      solved,
  output logic [63:0]               oPlayer,
  output logic [63:0]               oOpponent,
  output logic signed [SCORE_W-1:0] res,
  output logic [4:0]                o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  typedef logic signed [SCORE_W-1:0] score_t;
  localparam score_t SCORE_MAX  = score_t'(64);
  localparam score_t SCORE_MIN  = -SCORE_MAX;
  localparam score_t SCORE_ZERO = score_t'(0);
  localparam logic [63:0] INNER_COLS = 64'h7E7E7E7E7E7E7E7E;

  function automatic logic [63:0] shift_dir(input logic [63:0] b, input int unsigned d);
    case (d)
      0:       shift_dir = b << 1;
      1:       shift_dir = b >> 1;
      2:       shift_dir = b << 8;
      3:       shift_dir = b >> 8;
      4:       shift_dir = b << 7;
      5:       shift_dir = b >> 7;
      6:       shift_dir = b << 9;
      default: shift_dir = b >> 9;
    endcase
  endfunction

  // Any direction with a horizontal component may only run through inner columns.
  function automatic logic [63:0] dir_mask(input int unsigned d);
    dir_mask = (d == 2 || d == 3) ? '1 : INNER_COLS;
  endfunction

  function automatic logic [63:0] legal_moves(input logic [63:0] p, input logic [63:0] q);
    logic [63:0] empty, om, t;
    legal_moves = '0;
    empty = ~(p | q);
    for (int unsigned d = 0; d < 8; d++) begin
      om = q & dir_mask(d);
      t  = shift_dir(p, d) & om;
      for (int unsigned k = 0; k < 5; k++) t = t | (shift_dir(t, d) & om);
      legal_moves = legal_moves | (shift_dir(t, d) & empty);
    end
  endfunction

  function automatic logic [63:0] flips_of(input logic [63:0] p, input logic [63:0] q,
                                           input logic [63:0] m);
    logic [63:0] om, f;
    flips_of = '0;
    for (int unsigned d = 0; d < 8; d++) begin
      om = q & dir_mask(d);
      f  = shift_dir(m, d) & om;
      for (int unsigned k = 0; k < 5; k++) f = f | (shift_dir(f, d) & om);
      if ((shift_dir(f, d) & p) != '0) flips_of = flips_of | f;
    end
  endfunction

  function automatic logic [6:0] popcnt(input logic [63:0] b);
    popcnt = '0;
    for (int unsigned i = 0; i < 64; i++) popcnt = popcnt + {6'd0, b[i]};
  endfunction

  logic [1:0]  state_q, state_d;
  logic [4:0]  sp_q, sp_d;
  score_t      res_q, res_d;
  logic [63:0] op_q, op_d, oo_q, oo_d;

  logic [63:0] fp_q    [MAX_DEPTH];
  logic [63:0] fo_q    [MAX_DEPTH];
  logic [63:0] fm_q    [MAX_DEPTH];
  score_t      fa_q    [MAX_DEPTH];
  score_t      fb_q    [MAX_DEPTH];
  score_t      fbest_q [MAX_DEPTH];
  logic        fpass_q [MAX_DEPTH];
  logic        ffresh_q[MAX_DEPTH];

  logic [63:0] top_p, top_o, top_mask, legal_top, legal_opp, eff_mask, move, flp;
  score_t      top_alpha, top_beta, top_best, ab_max, term_score, diff, emp;
  logic        top_pass, top_fresh, cut;
  logic [6:0]  pcp, pco;
  logic        act_push, act_pass, act_ret;
  score_t      ret_val, neg_ret, child_alpha, child_beta;
  logic [63:0] child_p, child_o, new_mask;
  logic [4:0]  child_idx, par_idx;

  always_comb begin
    top_p     = fp_q[sp_q];
    top_o     = fo_q[sp_q];
    top_mask  = fm_q[sp_q];
    top_alpha = fa_q[sp_q];
    top_beta  = fb_q[sp_q];
    top_best  = fbest_q[sp_q];
    top_pass  = fpass_q[sp_q];
    top_fresh = ffresh_q[sp_q];
    legal_top = legal_moves(top_p, top_o);
    legal_opp = legal_moves(top_o, top_p);
    // The move mask is generated on the frame's first step rather than at push time.
    eff_mask  = top_fresh ? legal_top : top_mask;
    move      = eff_mask & (~eff_mask + 64'd1);
    flp       = flips_of(top_p, top_o, move);
    cut       = top_best >= top_beta;
    ab_max    = (top_alpha > top_best) ? top_alpha : top_best;
    pcp       = popcnt(top_p);
    pco       = popcnt(top_o);
    diff      = score_t'(pcp) - score_t'(pco);
    emp       = score_t'(7'd64 - pcp - pco);
    if (diff > SCORE_ZERO)      term_score = diff + emp;
    else if (diff < SCORE_ZERO) term_score = diff - emp;
    else                        term_score = SCORE_ZERO;
  end

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    res_d       = res_q;
    op_d        = op_q;
    oo_d        = oo_q;
    act_push    = 1'b0;
    act_pass    = 1'b0;
    act_ret     = 1'b0;
    ret_val     = top_best;
    child_p     = top_o;
    child_o     = top_p;
    child_alpha = -top_beta;
    child_beta  = -ab_max;
    new_mask    = eff_mask & ~move;
    child_idx   = sp_q + 5'd1;
    par_idx     = sp_q - 5'd1;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_SEARCH;
          op_d    = iPlayer;
          oo_d    = iOpponent;
          sp_d    = '0;
        end
      end
      S_SEARCH: begin
        if (top_fresh && legal_top == '0) begin
          // A pass frame's parent already proved the opponent has no move.
          if (top_pass || legal_opp == '0) begin
            act_ret = 1'b1;
            ret_val = term_score;
          end else begin
            act_pass = 1'b1;
          end
        end else if (eff_mask != '0 && !cut) begin
          act_push = 1'b1;
          child_p  = top_o & ~flp;
          child_o  = top_p | flp | move;
        end else begin
          act_ret = 1'b1;
        end
        if (act_push || act_pass) sp_d = child_idx;
        if (act_ret) begin
          if (sp_q == '0) begin
            state_d = S_DONE;
            res_d   = ret_val;
          end else begin
            sp_d = par_idx;
          end
        end
      end
      S_DONE: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    neg_ret = -ret_val;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      res_q   <= '0;
      op_q    <= '0;
      oo_q    <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      res_q   <= res_d;
      op_q    <= op_d;
      oo_q    <= oo_d;
      if (state_q == S_IDLE && enable) begin
        fp_q[0]     <= iPlayer;
        fo_q[0]     <= iOpponent;
        fm_q[0]     <= '0;
        fa_q[0]     <= SCORE_MIN;
        fb_q[0]     <= SCORE_MAX;
        fbest_q[0]  <= SCORE_MIN;
        fpass_q[0]  <= 1'b0;
        ffresh_q[0] <= 1'b1;
      end
      if (act_push || act_pass) begin
        fm_q[sp_q]          <= act_push ? new_mask : '0;
        ffresh_q[sp_q]      <= 1'b0;
        fp_q[child_idx]     <= child_p;
        fo_q[child_idx]     <= child_o;
        fm_q[child_idx]     <= '0;
        fa_q[child_idx]     <= child_alpha;
        fb_q[child_idx]     <= child_beta;
        fbest_q[child_idx]  <= SCORE_MIN;
        fpass_q[child_idx]  <= act_pass;
        ffresh_q[child_idx] <= 1'b1;
      end
      if (act_ret && sp_q != '0) begin
        if (neg_ret > fbest_q[par_idx]) fbest_q[par_idx] <= neg_ret;
      end
    end
  end

  assign solved    = (state_q == S_DONE);
  assign oPlayer   = op_q;
  assign oOpponent = oo_q;
  assign res       = res_q;
  assign o         = sp_q;

endmodule

// File: tb/tb_othello_pipeline.sv
// Scoreboard bench for othello_pipeline: expected scores are queued at launch and
// compared when solved rises; each scenario task checks its own control behaviour.
module tb_othello_pipeline;

  localparam logic [63:0] POS_P  = 64'h001F03070B15FF01;
  localparam logic [63:0] POS_O  = 64'h7F207CF8F4EA00FE;
  localparam logic [63:0] PASS_P = 64'h0000000000000002;
  localparam logic [63:0] PASS_O = 64'hFFFFFFFFFFFFFFFC;
  localparam int BUDGET = 20000;

  logic              iCLOCK = 1'b0;
  logic              iRESET = 1'b0;
  logic              enable = 1'b0;
  logic [63:0]       iPlayer = '0;
  logic [63:0]       iOpponent = '0;
  logic              solved;
  logic [63:0]       oPlayer, oOpponent;
  logic signed [7:0] res;
  logic [4:0]        o;

  int checks = 0;
  int errors = 0;
  logic signed [7:0] sb[$];
  logic prev_solved = 1'b0;
  logic signed [7:0] exp_r;

  othello_pipeline #(.MAX_DEPTH(24), .SCORE_W(8)) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .enable(enable),
    .iPlayer(iPlayer), .iOpponent(iOpponent),
    .solved(solved), .oPlayer(oPlayer), .oOpponent(oOpponent),
    .res(res), .o(o)
  );

  always #5 iCLOCK = ~iCLOCK;

  // Scoreboard monitor: one pending expected score per launched solve.
  always begin
    @(posedge iCLOCK);
    #1;
    if (solved === 1'b1 && prev_solved !== 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: solved rose with res=%0d, required no pending solve", res);
      end else begin
        exp_r = sb.pop_front();
        if (res !== exp_r) begin
          errors++;
          $display("FAIL sb_res: res=%0d required %0d", res, exp_r);
        end
      end
    end
    prev_solved = solved;
  end

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic launch(input logic [63:0] p, input logic [63:0] q,
                        input bit push, input logic signed [7:0] expv);
    iPlayer   = p;
    iOpponent = q;
    enable    = 1'b1;
    if (push) sb.push_back(expv);
  endtask

  task automatic wait_solved(output bit ok, output int cyc, output int maxo, output int o_at2);
    ok = 0; cyc = 0; maxo = 0; o_at2 = -1;
    for (int c = 1; c <= BUDGET; c++) begin
      tick();
      if (c == 2) o_at2 = int'(o);
      if (int'(o) > maxo) maxo = int'(o);
      if (solved === 1'b1) begin
        ok = 1;
        cyc = c;
        break;
      end
    end
  endtask

  task automatic release_enable();
    enable = 1'b0;
    tick();
  endtask

  function automatic logic [63:0] bswap(input logic [63:0] b);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = b[(7-i)*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] hmirror(input logic [63:0] b);
    logic [63:0] r;
    for (int row = 0; row < 8; row++)
      for (int col = 0; col < 8; col++) r[row*8 + col] = b[row*8 + 7 - col];
    return r;
  endfunction

  task automatic test_reset();
    iRESET = 1'b1; enable = 1'b0;
    iPlayer = {$urandom, $urandom}; iOpponent = {$urandom, $urandom};
    tick(); tick();
    checks++; if (solved !== 1'b0) begin errors++; $display("FAIL reset_solved: got %b required 0", solved); end
    checks++; if (o !== 5'd0) begin errors++; $display("FAIL reset_o: got %0d required 0", o); end
    checks++; if (res !== 8'sd0) begin errors++; $display("FAIL reset_res: got %0d required 0", res); end
    checks++; if (oPlayer !== 64'd0) begin errors++; $display("FAIL reset_oPlayer: got %h required 0", oPlayer); end
    checks++; if (oOpponent !== 64'd0) begin errors++; $display("FAIL reset_oOpponent: got %h required 0", oOpponent); end
    iRESET = 1'b0;
  endtask

  task automatic test_idle();
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      iPlayer = {$urandom, $urandom}; iOpponent = {$urandom, $urandom};
      tick();
      checks++;
      if (o !== 5'd0 || solved !== 1'b0 || oPlayer !== 64'd0) begin
        errors++;
        $display("FAIL idle_cycle%0d: o=%0d solved=%b oPlayer=%h required 0/0/0", i, o, solved, oPlayer);
      end
    end
  endtask

  task automatic test_main_solve();
    bit ok; int cyc, maxo, o2;
    launch(POS_P, POS_O, 1, 8'sd14);
    tick();
    iPlayer = {$urandom, $urandom}; iOpponent = {$urandom, $urandom};
    wait_solved(ok, cyc, maxo, o2);
    checks++; if (!ok) begin errors++; $display("FAIL main_timeout: solved=%b required 1 within %0d cycles", solved, BUDGET); end
    checks++; if (oPlayer !== POS_P) begin errors++; $display("FAIL main_oPlayer: got %h required %h", oPlayer, POS_P); end
    checks++; if (oOpponent !== POS_O) begin errors++; $display("FAIL main_oOpponent: got %h required %h", oOpponent, POS_O); end
    checks++; if (o !== 5'd0) begin errors++; $display("FAIL main_o_done: got %0d required 0", o); end
    checks++; if (maxo < 1) begin errors++; $display("FAIL main_depth: max o=%0d required >=1", maxo); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (solved !== 1'b1 || res !== 8'sd14) begin
        errors++;
        $display("FAIL done_hold%0d: solved=%b res=%0d required 1/14", i, solved, res);
      end
    end
    release_enable();
    checks++; if (solved !== 1'b0) begin errors++; $display("FAIL done_drop: solved=%b required 0", solved); end
    checks++; if (res !== 8'sd14) begin errors++; $display("FAIL done_res_kept: res=%0d required 14", res); end
  endtask

  task automatic test_full_board();
    bit ok; int cyc, maxo, o2;
    launch('1, '0, 1, 8'sd64);
    wait_solved(ok, cyc, maxo, o2);
    checks++; if (!ok || cyc > 2) begin errors++; $display("FAIL full_white_latency: cycles=%0d ok=%0d required <=2", cyc, ok); end
    release_enable();
    launch('0, '1, 1, -8'sd64);
    wait_solved(ok, cyc, maxo, o2);
    checks++; if (!ok || cyc > 2) begin errors++; $display("FAIL full_black_latency: cycles=%0d ok=%0d required <=2", cyc, ok); end
    release_enable();
  endtask

  task automatic test_pass();
    bit ok; int cyc, maxo, o2;
    launch(PASS_P, PASS_O, 1, -8'sd64);
    wait_solved(ok, cyc, maxo, o2);
    checks++; if (!ok) begin errors++; $display("FAIL pass_timeout: solved=%b required 1", solved); end
    checks++; if (o2 != 1) begin errors++; $display("FAIL pass_push: o after first step=%0d required 1", o2); end
    release_enable();
    launch(PASS_O, PASS_P, 1, 8'sd64);
    wait_solved(ok, cyc, maxo, o2);
    checks++; if (!ok) begin errors++; $display("FAIL pass_swapped_timeout: solved=%b required 1", solved); end
    release_enable();
  endtask

  task automatic test_symmetry();
    bit ok; int cyc, maxo, o2;
    launch(bswap(POS_P), bswap(POS_O), 1, 8'sd14);
    wait_solved(ok, cyc, maxo, o2);
    checks++; if (!ok) begin errors++; $display("FAIL sym_vflip_timeout: solved=%b required 1", solved); end
    release_enable();
    launch(hmirror(POS_P), hmirror(POS_O), 1, 8'sd14);
    wait_solved(ok, cyc, maxo, o2);
    checks++; if (!ok) begin errors++; $display("FAIL sym_hflip_timeout: solved=%b required 1", solved); end
    release_enable();
  endtask

  task automatic test_reset_mid_search();
    bit ok; int cyc, maxo, o2;
    launch(POS_P, POS_O, 0, 8'sd0);
    for (int i = 0; i < 6; i++) tick();
    checks++; if (solved !== 1'b0) begin errors++; $display("FAIL midrst_early_done: solved=%b required 0", solved); end
    iRESET = 1'b1; enable = 1'b0;
    tick();
    checks++;
    if (solved !== 1'b0 || o !== 5'd0 || oPlayer !== 64'd0) begin
      errors++;
      $display("FAIL midrst_state: solved=%b o=%0d oPlayer=%h required 0/0/0", solved, o, oPlayer);
    end
    iRESET = 1'b0;
    tick();
    launch(POS_P, POS_O, 1, 8'sd14);
    wait_solved(ok, cyc, maxo, o2);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_restart_timeout: solved=%b required 1", solved); end
    release_enable();
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc, maxo, o2;
    launch('1, '0, 1, 8'sd64);
    wait_solved(ok, cyc, maxo, o2);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout: solved=%b required 1", solved); end
    release_enable();
    checks++; if (solved !== 1'b0) begin errors++; $display("FAIL b2b_drop: solved=%b required 0", solved); end
    launch(POS_P, POS_O, 1, 8'sd14);
    wait_solved(ok, cyc, maxo, o2);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout: solved=%b required 1", solved); end
    checks++; if (oPlayer !== POS_P) begin errors++; $display("FAIL b2b_oPlayer: got %h required %h", oPlayer, POS_P); end
    release_enable();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_main_solve();
    test_full_board();
    test_pass();
    test_symmetry();
    test_reset_mid_search();
    test_back_to_back();
    tick(); tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected results pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/othello_pipeline.md
Name: othello_pipeline

Overview:
- Hardware Othello endgame solver.
- Takes a root position as two 64-bit bitboards: side to move, and opponent.
- Runs an iterative depth-first negamax search with alpha-beta pruning over an internal frame stack, one search step per clock.
- Reports the exact final disc differential for the side to move. Sits behind a host/test wrapper that loads a position and polls `solved`.

Parameters:
- MAX_DEPTH, 24: number of stack frames. Bounds empties plus passes searched; must be ≤ 31.
- SCORE_W, 8: signed score width, range -64..+64.

Ports:
- iCLOCK  input  1  rising-edge clock.
- iRESET  input  1  synchronous active-high reset.
- enable  input  1  level start request; position is latched on the first rising edge with enable=1 while IDLE.
- iPlayer  input  64  stones of the side to move. Bit = row*8+col.
- iOpponent  input  64  opponent stones. Must be disjoint from iPlayer.
- solved  output  1  high while result is valid (DONE state).
- oPlayer  output  64  latched root player board.
- oOpponent  output  64  latched root opponent board.
- res  output  8 signed  exact negamax score for the root side to move.
- o  output  5  current stack pointer (search depth); 0 when IDLE or DONE.

Behaviour:
- Reset (synchronous, iRESET=1 at rising edge) has priority over everything, including mid-search:
  - state=IDLE; solved=0; res=0; o=0; oPlayer=0; oOpponent=0; stack contents don't-care.
- States: IDLE, SEARCH, DONE.
- IDLE, enable=1 at an edge:
  - latch iPlayer/iOpponent into oPlayer/oOpponent and into frame 0;
  - set frame 0 alpha=-64, beta=+64, pass flag=0;
  - o=0; go to SEARCH.
  - Inputs are ignored at all other times.
- Frame contents: P, O, remaining-move mask, alpha, beta, best, pass flag.
  - On frame entry, mask = legal moves of P against O. Legal-move and flip logic:
    - 8-direction shift-and-mask on the bitboards;
    - column masks prevent wrap between rows;
    - a move is legal iff it flips ≥1 stone.
- One step per cycle in SEARCH. The top frame takes exactly one action:
  - (a) Mask nonempty, not cut off:
    - take the lowest set bit of the mask and clear it;
    - compute flips;
    - push child frame with P'=O&~flips and O'=P|flips|move, window (-beta, -max(alpha,best)), best=-64;
    - o increments.
  - (b) Mask empty on entry (no legal move):
    - if the opponent also has no move, the frame is terminal;
    - otherwise push a pass frame (P and O swapped, window negated, pass flag=1).
  - (c) Terminal: score = popcount(P) - popcount(O).
    - If score > 0, add the empty count; if < 0, subtract it; 0 stays 0.
    - Return the score to the parent.
  - (d) Mask exhausted, or best ≥ beta: return best to the parent.
- Return to parent: pop (o decrements); parent best = max(best, -childscore).
- Return from frame 0: res = value; o=0; state=DONE; solved=1.
- DONE:
  - solved, res, oPlayer, oOpponent held stable while enable=1;
  - enable=0 → IDLE with solved=0 (res retained).
- Enable deasserted mid-SEARCH has no effect; the search completes.
- Stack overflow (o would exceed MAX_DEPTH-1) cannot occur for legal positions with ≤ MAX_DEPTH/2 empties. Behaviour beyond that is undefined.
- Score arithmetic: 8-bit signed saturating to ±64. Negation is exact in that range.
- Latency: data dependent, but bounded. A 4-empty position must solve in far fewer than 300000 cycles (a few hundred typical).
- Any board symmetry of a position yields the same res.

Test Plan:
- Reset, then iPlayer=64'h001F03070B15FF01, iOpponent=64'h7F207CF8F4EA00FE (4 empties), enable=1:
  - solved rises within 300000 cycles;
  - res=14; oPlayer/oOpponent equal the inputs;
  - o returns to 0.
- Full board, iPlayer=64'hFFFFFFFFFFFFFFFF, iOpponent=0 → res=+64; swapped boards → res=-64, within ~2 cycles after start.
- Side to move has no legal move but opponent does:
  - a pass frame is pushed (o goes 0→1);
  - res equals the negated opponent-to-move result of the same position.
- Assert iRESET during SEARCH → next cycle solved=0, o=0, state IDLE. A subsequent enable restarts and reproduces res=14 for the first position.
- Hold enable=0 for 8 cycles after reset → o=0, solved=0, inputs ignored.
- In DONE, drop enable → solved falls next cycle. Re-raise it with a new position → a new solve.
